// File: rtl/can_ifs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : can_ifs_pkg
// Description : Shared types and default constants for the CAN interframe
//               space controller. Holds the 3-bit interframe state encoding,
//               the default parameter values and a small integer max helper
//               that is used to size the recessive bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package can_ifs_pkg;

    typedef enum logic [2:0] {
        S_INTEGRATE     = 3'd0,
        S_WAIT_EOF      = 3'd1,
        S_INTERMISSION  = 3'd2,
        S_OVERLOAD_WAIT = 3'd3,
        S_SUSPEND       = 3'd4,
        S_BUS_IDLE      = 3'd5
    } ifs_state_t;

    localparam int c_DEF_INTERMISSION_BITS = 3;
    localparam int c_DEF_SUSPEND_BITS      = 8;
    localparam int c_DEF_IDLE_DETECT_BITS  = 11;
    localparam int c_DEF_MAX_OVERLOADS     = 2;

    function automatic int ifs_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/recessive_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : recessive_bit_counter
// Description : Counts recessive bit samples for the interframe controller.
//               One instance is time-shared by the integration, intermission
//               and suspend phases; the caller selects the terminal value.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               clear         - synchronous clear, wins over count_en
//               count_en      - count one recessive sample this cycle
//               term_value    - number of recessive bits that ends the phase
//               count         - current count (registered)
//               term_hit      - this cycle's sample is the terminal one
// Revision    : 1.0 - initial release
// ============================================================================
module recessive_bit_counter
    import can_ifs_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    input  logic [CNT_W-1:0] term_value,
    output logic [CNT_W-1:0] count,
    output logic             term_hit
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);

    // Terminal is flagged on the sample that completes the run, so the
    // owning FSM can change phase on the same edge the count would reach it.
    assign term_hit = count_en && (w_count_inc == term_value);
    assign count    = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en) begin
            r_count <= w_count_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interframe_controller.sv
`default_nettype none
// ============================================================================
// Module      : interframe_controller
// Description : CAN interframe space controller. Handles bus integration,
//               intermission, suspend transmission, overload detection and
//               bus-idle / start-of-frame signalling. All outputs registered.
// Macro       : IFS_OVERLOAD_EN - when defined, dominant bits early in the
//               intermission request overload frames; otherwise they are
//               treated as start of frame and the overload outputs are 0.
// Ports       : clk, rst (async, active-high), enable, sample_point, rx_bit,
//               frame_complete, overload_end, was_transmitter,
//               is_error_passive, tx_pending  -> inputs
//               ifs_state, bit_counter, bus_idle, sof_detected, tx_start,
//               overload_request, overload_count, overload_limit,
//               integrated -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module interframe_controller
    import can_ifs_pkg::*;
#(
    parameter int INTERMISSION_BITS = c_DEF_INTERMISSION_BITS,
    parameter int SUSPEND_BITS      = c_DEF_SUSPEND_BITS,
    parameter int IDLE_DETECT_BITS  = c_DEF_IDLE_DETECT_BITS,
    parameter int MAX_OVERLOADS     = c_DEF_MAX_OVERLOADS,
    parameter int CNT_W             = $clog2(ifs_max(IDLE_DETECT_BITS, SUSPEND_BITS) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sample_point,
    input  logic             rx_bit,
    input  logic             frame_complete,
    input  logic             overload_end,
    input  logic             was_transmitter,
    input  logic             is_error_passive,
    input  logic             tx_pending,
    output logic [2:0]       ifs_state,
    output logic [CNT_W-1:0] bit_counter,
    output logic             bus_idle,
    output logic             sof_detected,
    output logic             tx_start,
    output logic             overload_request,
    output logic [1:0]       overload_count,
    output logic             overload_limit,
    output logic             integrated
);

    ifs_state_t       r_state;
    ifs_state_t       w_next_state;
    logic             r_bus_idle, r_sof, r_tx_start, r_integrated, r_tx_pending_d;
    logic             w_sof, w_tx_start, w_integrated;
    logic             w_fc_take, w_sample, w_rec, w_dom;
    logic             w_count_en, w_clear, w_term_hit, w_ovl_trigger;
    logic [CNT_W-1:0] w_term_value, w_count;

    // A frame_complete that the current phase acts on swallows any sample
    // arriving in the same cycle.
    assign w_fc_take  = frame_complete && (r_state inside {S_WAIT_EOF, S_INTERMISSION,
                                                           S_SUSPEND, S_BUS_IDLE});
    assign w_sample   = sample_point && !w_fc_take;
    assign w_rec      = w_sample && rx_bit;
    assign w_dom      = w_sample && !rx_bit;
    assign w_count_en = w_rec && (r_state inside {S_INTEGRATE, S_INTERMISSION, S_SUSPEND});

    always_comb begin
        case (r_state)
            S_INTEGRATE: w_term_value = CNT_W'(IDLE_DETECT_BITS);
            S_SUSPEND:   w_term_value = CNT_W'(SUSPEND_BITS);
            default:     w_term_value = CNT_W'(INTERMISSION_BITS);
        endcase
    end

    // Counter restarts on every phase change, on a restarting frame_complete
    // and on any dominant bit while integrating.
    assign w_clear = !enable || w_fc_take || (w_next_state != r_state)
                     || ((r_state == S_INTEGRATE) && w_dom);

    recessive_bit_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .count_en   (w_count_en),
        .term_value (w_term_value),
        .count      (w_count),
        .term_hit   (w_term_hit)
    );

`ifdef IFS_OVERLOAD_EN
    logic [1:0] r_ovl_count;
    logic       r_ovl_req, r_ovl_limit;
    logic       w_early_bit, w_ovl_room;

    // Bit index inside the intermission equals the recessive count so far.
    assign w_early_bit   = (w_count < CNT_W'(INTERMISSION_BITS - 1));
    assign w_ovl_room    = (32'(r_ovl_count) < MAX_OVERLOADS);
    assign w_ovl_trigger = (r_state == S_INTERMISSION) && w_dom && w_early_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovl_count <= 2'd0;
            r_ovl_req   <= 1'b0;
            r_ovl_limit <= 1'b0;
        end else if (!enable) begin
            r_ovl_count <= 2'd0;
            r_ovl_req   <= 1'b0;
            r_ovl_limit <= 1'b0;
        end else begin
            r_ovl_req   <= 1'b0;
            r_ovl_limit <= 1'b0;
            if (w_ovl_trigger) begin
                if (w_ovl_room) begin
                    r_ovl_count <= r_ovl_count + 2'd1;
                    r_ovl_req   <= 1'b1;
                end else begin
                    r_ovl_limit <= 1'b1;
                end
            end else if ((r_state == S_INTERMISSION) && w_term_hit) begin
                r_ovl_count <= 2'd0;
            end
        end
    end

    assign overload_request = r_ovl_req;
    assign overload_count   = r_ovl_count;
    assign overload_limit   = r_ovl_limit;
`else
    logic w_unused;
    assign w_unused         = overload_end ^ (MAX_OVERLOADS != 0);
    assign w_ovl_trigger    = 1'b0;
    assign overload_request = 1'b0;
    assign overload_count   = 2'd0;
    assign overload_limit   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INTEGRATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INTEGRATE: begin
                if (w_term_hit) w_next_state = S_BUS_IDLE;
            end
            S_WAIT_EOF: begin
                if (w_fc_take) w_next_state = S_INTERMISSION;
            end
            S_INTERMISSION: begin
                if (w_fc_take) begin
                    w_next_state = S_INTERMISSION;
                end else if (w_term_hit) begin
                    w_next_state = (was_transmitter && is_error_passive) ? S_SUSPEND : S_BUS_IDLE;
                end else if (w_dom) begin
`ifdef IFS_OVERLOAD_EN
                    if (w_ovl_trigger && w_ovl_room) w_next_state = S_OVERLOAD_WAIT;
                    else
`endif
                    w_next_state = S_WAIT_EOF;
                end
            end
`ifdef IFS_OVERLOAD_EN
            S_OVERLOAD_WAIT: begin
                if (overload_end) w_next_state = S_INTERMISSION;
            end
`endif
            S_SUSPEND: begin
                if (w_fc_take)       w_next_state = S_INTERMISSION;
                else if (w_term_hit) w_next_state = S_BUS_IDLE;
                else if (w_dom)      w_next_state = S_WAIT_EOF;
            end
            S_BUS_IDLE: begin
                if (w_fc_take)  w_next_state = S_INTERMISSION;
                else if (w_dom) w_next_state = S_WAIT_EOF;
            end
            default: w_next_state = S_INTEGRATE;
        endcase
        if (!enable) w_next_state = S_INTEGRATE;
    end

    // Output logic (values registered below)
    always_comb begin
        w_sof        = 1'b0;
        w_tx_start   = 1'b0;
        w_integrated = r_integrated;
        case (r_state)
            S_INTEGRATE: begin
                if (w_term_hit) w_integrated = 1'b1;
            end
            S_INTERMISSION: begin
                if (!w_fc_take && (w_next_state == S_BUS_IDLE)) w_tx_start = tx_pending;
                // Limit hit also lands in WAIT_EOF but is not a frame start.
                if ((w_next_state == S_WAIT_EOF) && !w_ovl_trigger) w_sof = 1'b1;
            end
            S_SUSPEND: begin
                if (w_next_state == S_BUS_IDLE) w_tx_start = tx_pending;
                if (w_next_state == S_WAIT_EOF) w_sof = 1'b1;
            end
            S_BUS_IDLE: begin
                if (w_next_state == S_WAIT_EOF) begin
                    w_sof = 1'b1;
                end else if ((w_next_state == S_BUS_IDLE) && tx_pending && !r_tx_pending_d) begin
                    w_tx_start = 1'b1;
                end
            end
            default: ;
        endcase
        if (!enable) begin
            w_sof        = 1'b0;
            w_tx_start   = 1'b0;
            w_integrated = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_idle     <= 1'b0;
            r_sof          <= 1'b0;
            r_tx_start     <= 1'b0;
            r_integrated   <= 1'b0;
            r_tx_pending_d <= 1'b0;
        end else begin
            r_bus_idle     <= (w_next_state == S_BUS_IDLE);
            r_sof          <= w_sof;
            r_tx_start     <= w_tx_start;
            r_integrated   <= w_integrated;
            r_tx_pending_d <= tx_pending;
        end
    end

    assign ifs_state    = r_state;
    assign bit_counter  = w_count;
    assign bus_idle     = r_bus_idle;
    assign sof_detected = r_sof;
    assign tx_start     = r_tx_start;
    assign integrated   = r_integrated;

endmodule
`default_nettype wire

// File: tb/tb_interframe_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interframe_controller
// Description : Self-checking bench for interframe_controller. A bus-level
//               model predicts every output each cycle; directed sequences
//               add hand-computed literal checks. Honours IFS_OVERLOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interframe_controller;
    import can_ifs_pkg::*;

    localparam int IB  = 3;
    localparam int SB  = 8;
    localparam int IDB = 11;
    localparam int MXO = 2;

    logic       clk = 1'b0;
    logic       rst, enable, sample_point, rx_bit, frame_complete, overload_end;
    logic       was_transmitter, is_error_passive, tx_pending;
    logic [2:0] ifs_state;
    logic [3:0] bit_counter;
    logic       bus_idle, sof_detected, tx_start, overload_request, overload_limit, integrated;
    logic [1:0] overload_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    interframe_controller dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .sample_point     (sample_point),
        .rx_bit           (rx_bit),
        .frame_complete   (frame_complete),
        .overload_end     (overload_end),
        .was_transmitter  (was_transmitter),
        .is_error_passive (is_error_passive),
        .tx_pending       (tx_pending),
        .ifs_state        (ifs_state),
        .bit_counter      (bit_counter),
        .bus_idle         (bus_idle),
        .sof_detected     (sof_detected),
        .tx_start         (tx_start),
        .overload_request (overload_request),
        .overload_count   (overload_count),
        .overload_limit   (overload_limit),
        .integrated       (integrated)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- bus-level model ----------------
    ifs_state_t m_phase;
    int         m_run, m_ovl;
    bit         m_integ, m_sof, m_tx, m_oreq, m_olim, m_pend_d;

    always @(posedge clk or posedge rst) begin : model
        bit fc, smp;
        if (rst) begin
            m_phase = S_INTEGRATE; m_run = 0; m_ovl = 0; m_integ = 0;
            m_sof = 0; m_tx = 0; m_oreq = 0; m_olim = 0; m_pend_d = 0;
        end else begin
            m_sof = 0; m_tx = 0; m_oreq = 0; m_olim = 0;
            if (!enable) begin
                m_phase = S_INTEGRATE; m_run = 0; m_ovl = 0; m_integ = 0;
            end else begin
                fc  = frame_complete && (m_phase inside {S_WAIT_EOF, S_INTERMISSION, S_SUSPEND, S_BUS_IDLE});
                smp = sample_point && !fc;
                if (fc) begin
                    m_phase = S_INTERMISSION; m_run = 0;
                end else begin
                    case (m_phase)
                        S_INTEGRATE: if (smp) begin
                            if (rx_bit) begin
                                m_run++;
                                if (m_run == IDB) begin m_phase = S_BUS_IDLE; m_run = 0; m_integ = 1; end
                            end else m_run = 0;
                        end
                        S_INTERMISSION: if (smp) begin
                            if (rx_bit) begin
                                m_run++;
                                if (m_run == IB) begin
                                    m_ovl = 0; m_run = 0;
                                    if (was_transmitter && is_error_passive) m_phase = S_SUSPEND;
                                    else begin m_phase = S_BUS_IDLE; m_tx = tx_pending; end
                                end
                            end else begin
`ifdef IFS_OVERLOAD_EN
                                if (m_run < IB - 1) begin
                                    if (m_ovl < MXO) begin m_ovl++; m_oreq = 1; m_phase = S_OVERLOAD_WAIT; end
                                    else begin m_olim = 1; m_phase = S_WAIT_EOF; end
                                end else
`endif
                                begin m_sof = 1; m_phase = S_WAIT_EOF; end
                                m_run = 0;
                            end
                        end
                        S_OVERLOAD_WAIT: if (overload_end) begin m_phase = S_INTERMISSION; m_run = 0; end
                        S_SUSPEND: if (smp) begin
                            if (rx_bit) begin
                                m_run++;
                                if (m_run == SB) begin m_phase = S_BUS_IDLE; m_tx = tx_pending; m_run = 0; end
                            end else begin m_sof = 1; m_phase = S_WAIT_EOF; m_run = 0; end
                        end
                        S_BUS_IDLE: begin
                            if (smp && !rx_bit) begin m_sof = 1; m_phase = S_WAIT_EOF; end
                            else if (tx_pending && !m_pend_d) m_tx = 1;
                        end
                        default: ;
                    endcase
                end
            end
            m_pend_d = tx_pending;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_state",    int'(ifs_state),        int'(m_phase));
            chk("m_counter",  int'(bit_counter),      m_run);
            chk("m_bus_idle", int'(bus_idle),         int'(m_phase == S_BUS_IDLE));
            chk("m_sof",      int'(sof_detected),     int'(m_sof));
            chk("m_tx_start", int'(tx_start),         int'(m_tx));
            chk("m_ovl_req",  int'(overload_request), int'(m_oreq));
            chk("m_ovl_cnt",  int'(overload_count),   m_ovl);
            chk("m_ovl_lim",  int'(overload_limit),   int'(m_olim));
            chk("m_integ",    int'(integrated),       int'(m_integ));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic samp(input logic b);
        @(negedge clk);
        sample_point = 1'b1; rx_bit = b;
        @(negedge clk);
        sample_point = 1'b0; rx_bit = 1'b1;
    endtask

    task automatic fc_pulse();
        frame_complete = 1'b1;
        @(negedge clk);
        frame_complete = 1'b0;
    endtask

    task automatic ovl_end_pulse();
        overload_end = 1'b1;
        @(negedge clk);
        overload_end = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; sample_point = 1'b0; rx_bit = 1'b1;
        frame_complete = 1'b0; overload_end = 1'b0; was_transmitter = 1'b0;
        is_error_passive = 1'b0; tx_pending = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state",   int'(ifs_state), 0);
        chk("rst_counter", int'(bit_counter), 0);
        chk("rst_integ",   int'(integrated), 0);
        chk("rst_idle",    int'(bus_idle), 0);
        rst = 1'b0;

        // Integration with a dominant restart at sample 6
        repeat (5) samp(1'b1);
        chk("int_cnt5", int'(bit_counter), 5);
        samp(1'b0);
        chk("int_dom_clr", int'(bit_counter), 0);
        repeat (10) samp(1'b1);
        chk("int_10_not_yet", int'(integrated), 0);
        samp(1'b1);
        chk("int_done_integ", int'(integrated), 1);
        chk("int_done_idle",  int'(bus_idle), 1);

        // tx_pending rising in bus idle
        tx_pending = 1'b1;
        @(negedge clk);
        chk("idle_tx_rise", int'(tx_start), 1);
        @(negedge clk);
        chk("idle_tx_once", int'(tx_start), 0);

        // Intermission to bus idle, error-active transmitter
        was_transmitter = 1'b1; is_error_passive = 1'b0;
        fc_pulse();
        chk("fc_to_inter", int'(ifs_state), int'(S_INTERMISSION));
        repeat (2) samp(1'b1);
        chk("inter_no_tx_yet", int'(tx_start), 0);
        samp(1'b1);
        chk("inter_tx_start", int'(tx_start), 1);
        chk("inter_bus_idle", int'(bus_idle), 1);

        // Error-passive transmitter: suspend then idle
        is_error_passive = 1'b1;
        fc_pulse();
        repeat (3) samp(1'b1);
        chk("susp_enter", int'(ifs_state), int'(S_SUSPEND));
        chk("susp_no_tx", int'(tx_start), 0);
        repeat (7) samp(1'b1);
        chk("susp_7", int'(ifs_state), int'(S_SUSPEND));
        samp(1'b1);
        chk("susp_tx_start", int'(tx_start), 1);
        chk("susp_idle", int'(bus_idle), 1);

        // Dominant at suspend bit 4
        fc_pulse();
        repeat (3) samp(1'b1);
        repeat (4) samp(1'b1);
        chk("susp_cnt4", int'(bit_counter), 4);
        samp(1'b0);
        chk("susp_dom_sof", int'(sof_detected), 1);
        chk("susp_dom_state", int'(ifs_state), int'(S_WAIT_EOF));
        chk("susp_dom_no_tx", int'(tx_start), 0);

        // Dominant at last intermission bit is a start of frame
        is_error_passive = 1'b0;
        fc_pulse();
        repeat (2) samp(1'b1);
        samp(1'b0);
        chk("inter2_sof", int'(sof_detected), 1);
        chk("inter2_no_ovl", int'(overload_request), 0);
        chk("inter2_state", int'(ifs_state), int'(S_WAIT_EOF));

        // frame_complete wins over a coincident sample
        fc_pulse();
        repeat (2) samp(1'b1);
        chk("fc_pre_cnt", int'(bit_counter), 2);
        frame_complete = 1'b1; sample_point = 1'b1; rx_bit = 1'b1;
        @(negedge clk);
        frame_complete = 1'b0; sample_point = 1'b0;
        chk("fc_wins_cnt", int'(bit_counter), 0);
        chk("fc_wins_state", int'(ifs_state), int'(S_INTERMISSION));

        // Dominant at intermission bit 0
        samp(1'b0);
`ifdef IFS_OVERLOAD_EN
        chk("ovl1_req", int'(overload_request), 1);
        chk("ovl1_cnt", int'(overload_count), 1);
        chk("ovl1_state", int'(ifs_state), int'(S_OVERLOAD_WAIT));
        ovl_end_pulse();
        chk("ovl1_back", int'(ifs_state), int'(S_INTERMISSION));
        samp(1'b0);
        chk("ovl2_req", int'(overload_request), 1);
        chk("ovl2_cnt", int'(overload_count), 2);
        ovl_end_pulse();
        samp(1'b0);
        chk("ovl3_limit", int'(overload_limit), 1);
        chk("ovl3_no_req", int'(overload_request), 0);
        chk("ovl3_state", int'(ifs_state), int'(S_WAIT_EOF));
`else
        chk("noovl_sof", int'(sof_detected), 1);
        chk("noovl_req", int'(overload_request), 0);
        chk("noovl_cnt", int'(overload_count), 0);
        chk("noovl_lim", int'(overload_limit), 0);
        chk("noovl_state", int'(ifs_state), int'(S_WAIT_EOF));
        ovl_end_pulse();
        chk("noovl_end_ign", int'(ifs_state), int'(S_WAIT_EOF));
`endif

        // enable low forces re-integration
        fc_pulse();
        samp(1'b1);
        enable = 1'b0;
        @(negedge clk);
        chk("en_state", int'(ifs_state), int'(S_INTEGRATE));
        chk("en_integ", int'(integrated), 0);
        chk("en_cnt", int'(bit_counter), 0);
        enable = 1'b1;
        repeat (11) samp(1'b1);
        chk("en_reint", int'(bus_idle), 1);

        // Reset mid-frame needs full integration
        fc_pulse();
        samp(1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", int'(ifs_state), int'(S_INTEGRATE));
        chk("mid_rst_integ", int'(integrated), 0);
        rst = 1'b0;
        repeat (10) samp(1'b1);
        chk("mid_rst_10", int'(bus_idle), 0);
        samp(1'b1);
        chk("mid_rst_11", int'(bus_idle), 1);

        // Fresh tx request while idle
        tx_pending = 1'b0;
        @(negedge clk);
        tx_pending = 1'b1;
        @(negedge clk);
        chk("idle_tx_rise2", int'(tx_start), 1);
        samp(1'b0);
        chk("idle_sof", int'(sof_detected), 1);
        chk("idle_sof_state", int'(ifs_state), int'(S_WAIT_EOF));
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
